xor_apuf_ctrl: RTL

- Clocked controller for an N-way XOR arbiter PUF array. The array itself stays external and gate-delay based.
- Accepts a challenge over a valid/ready handshake, sparsifies it, and drives the shared start signal through repeated precharge/fire cycles.
- Samples each arbiter through a synchronizer, majority-votes each PUF over REPS races, and returns the XOR-reduced response with a stability flag.
- Sits between the enrolment/authentication logic and the arbiter PUF stage instances.

---
 rtl/xapuf_pkg.sv | 39 +++
 rtl/xor_apuf_ctrl_if.sv | 33 +++
 rtl/xapuf_sync2.sv | 22 ++
 rtl/xor_apuf_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/xapuf_pkg.sv
// Shared types and helpers for the XOR arbiter PUF controller.
// Holds the FSM state enum, challenge keep-mask and counter widths.
package xapuf_pkg;

  localparam int MAX_CHAL_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    FIRE,
    SAMPLE,
    VOTE,
    DONE
  } state_t;

  function automatic int cnt_w(int reps);
    return $clog2(reps + 1);
  endfunction

  function automatic int rep_w(int reps);
    return (reps > 1) ? $clog2(reps) : 1;
  endfunction

  // Bit i is kept when i is a multiple of the stride.
  function automatic logic [MAX_CHAL_W-1:0] sparse_mask(
    int w,
    int stride
  );
    logic [MAX_CHAL_W-1:0] m;
    int s;
    s = (stride < 1) ? 1 : stride;
    m = '0;
    for (int i = 0; i < MAX_CHAL_W; i++)
      if (i < w && (i % s) == 0)
        m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/xor_apuf_ctrl_if.sv
// Request/response handshake bundle for xor_apuf_ctrl.
// master: requester side; slave: controller side.
interface xor_apuf_ctrl_if #(
  parameter int CHAL_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [CHAL_W-1:0] req_chal;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_bit;
  logic              rsp_stable;

  modport master (
    output req_valid,
    output req_chal,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_bit,
    input  rsp_stable
  );

  modport slave (
    input  req_valid,
    input  req_chal,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_bit,
    output rsp_stable
  );
endinterface

// File: rtl/xapuf_sync2.sv
// Per-bit 2-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synchronized out).
module xapuf_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/xor_apuf_ctrl.sv
// XOR arbiter PUF controller: precharge/fire races, vote, XOR.
// Ports: clk, rst_n, bus (slave), chal_o, start_o, arb_i;
// rsp_raw when XAPUF_RAW_OUT_EN is defined.
module xor_apuf_ctrl
  import xapuf_pkg::*;
#(
  parameter int CHAL_W        = 32,
  parameter int NUM_PUFS      = 3,
  parameter int SPARSE_STRIDE = 2,
  parameter int REPS          = 5,
  parameter int SETTLE        = 4,
  parameter int RACE_WAIT     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  xor_apuf_ctrl_if.slave      bus,
  output logic [CHAL_W-1:0]   chal_o,
  output logic                start_o,
  input  logic [NUM_PUFS-1:0] arb_i
`ifdef XAPUF_RAW_OUT_EN
  ,
  output logic [NUM_PUFS-1:0] rsp_raw
`endif
);

  localparam int CW = cnt_w(REPS);
  localparam int RW = rep_w(REPS);
  localparam int TMAX =
    (SETTLE > RACE_WAIT) ? SETTLE : RACE_WAIT;
  localparam int TW =
    (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [MAX_CHAL_W-1:0] MASK_FULL =
    sparse_mask(CHAL_W, SPARSE_STRIDE);
  localparam logic [CHAL_W-1:0] MASK =
    MASK_FULL[CHAL_W-1:0];

  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] RW_LAST  = TW'(RACE_WAIT - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPS - 1);
  localparam logic [CW-1:0] CNT_ALL  = CW'(REPS);

  state_t               state;
  logic [TW-1:0]        tmr;
  logic [RW-1:0]        rep;
  logic [CW-1:0]        cnt [NUM_PUFS];
  logic [NUM_PUFS-1:0]  arb_s;
  logic [NUM_PUFS-1:0]  maj;
  logic [NUM_PUFS-1:0]  unan;
  logic                 rsp_valid_q;
  logic                 rsp_bit_q;
  logic                 rsp_stable_q;

  xapuf_sync2 #(.W(NUM_PUFS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (arb_i),
    .q     (arb_s)
  );

  always_comb begin
    maj  = '0;
    unan = '0;
    for (int p = 0; p < NUM_PUFS; p++) begin
      maj[p]  = (2 * int'(cnt[p])) > REPS;
      unan[p] = (cnt[p] == '0) || (cnt[p] == CNT_ALL);
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_bit    = rsp_bit_q;
  assign bus.rsp_stable = rsp_stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= '0;
      rep          <= '0;
      chal_o       <= '0;
      start_o      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_bit_q    <= 1'b0;
      rsp_stable_q <= 1'b0;
      for (int p = 0; p < NUM_PUFS; p++)
        cnt[p] <= '0;
`ifdef XAPUF_RAW_OUT_EN
      rsp_raw      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            chal_o <= bus.req_chal & MASK;
            rep    <= '0;
            tmr    <= '0;
            for (int p = 0; p < NUM_PUFS; p++)
              cnt[p] <= '0;
            state  <= PRECH;
          end
        end
        PRECH: begin
          if (tmr == SET_LAST) begin
            tmr     <= '0;
            start_o <= 1'b1;
            state   <= FIRE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        FIRE: begin
          if (tmr == RW_LAST) begin
            tmr   <= '0;
            state <= SAMPLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SAMPLE: begin
          for (int p = 0; p < NUM_PUFS; p++)
            cnt[p] <= cnt[p] + CW'(arb_s[p]);
          // Drop start here so every race has the same width.
          start_o <= 1'b0;
          if (rep == REP_LAST) begin
            state <= VOTE;
          end else begin
            rep   <= rep + 1'b1;
            state <= PRECH;
          end
        end
        VOTE: begin
          rsp_bit_q    <= ^maj;
          rsp_stable_q <= &unan;
          start_o      <= 1'b0;
          rsp_valid_q  <= 1'b1;
`ifdef XAPUF_RAW_OUT_EN
          rsp_raw      <= maj;
`endif
          state        <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            chal_o      <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
